pe_array_stream: RTL and testbench

- Parametrised successor to the single-pixel background-removal processing element.
- Processes NUM_PIXELS pixels per beat over a frame of FRAME_BEATS beats in two phases:
  - SUM phase: accumulates RGB sums and derives the expected background colour (mean) internally.
  - BG phase: replaces every pixel within threshold of the mean with a programmable background colour.
- Sits between the pixel source and the frame writer; a controller sequences it via Start_Sum, Start_BgRemoval and Ack.

---
 rtl/pe_pkg.sv | 23 ++
 rtl/pe_lane.sv | 43 ++++
 rtl/pe_array_stream.sv | 230 +++++++++++++++++++++++
 tb/tb_pe_array_stream.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants, state encoding and width helper for the background-removal PE array.
package pe_pkg;

    localparam int unsigned PIX_W = 8;

    // One-hot encoding so each state flag is a direct register bit.
    typedef enum logic [6:0] {
        ST_INIT     = 7'b0000001,
        ST_SUM_INIT = 7'b0000010,
        ST_SUM      = 7'b0000100,
        ST_SUM_DONE = 7'b0001000,
        ST_BG_INIT  = 7'b0010000,
        ST_BG       = 7'b0100000,
        ST_BG_DONE  = 7'b1000000
    } pe_state_e;

    // Per-channel accumulator width that cannot overflow over a full-scale frame.
    function automatic int unsigned acc_width(input int unsigned log2_pixels,
                                              input int unsigned log2_beats);
        return PIX_W + log2_pixels + log2_beats;
    endfunction

endpackage

// File: rtl/pe_lane.sv
// Combinational per-lane background test and replacement mux.
module pe_lane
    import pe_pkg::*;
(
    input  logic [PIX_W-1:0] red,
    input  logic [PIX_W-1:0] green,
    input  logic [PIX_W-1:0] blue,
    input  logic [PIX_W-1:0] red_ref,
    input  logic [PIX_W-1:0] green_ref,
    input  logic [PIX_W-1:0] blue_ref,
    input  logic [PIX_W-1:0] threshold,
    input  logic [PIX_W-1:0] bg_red,
    input  logic [PIX_W-1:0] bg_green,
    input  logic [PIX_W-1:0] bg_blue,
    output logic [PIX_W-1:0] res_red_c,
    output logic [PIX_W-1:0] res_green_c,
    output logic [PIX_W-1:0] res_blue_c,
    output logic             is_bg_c
);

    localparam int unsigned DIFF_W = PIX_W + 1;

    logic [DIFF_W-1:0] diff_r;
    logic [DIFF_W-1:0] diff_g;
    logic [DIFF_W-1:0] diff_b;

    // Absolute differences without wrap, inclusive threshold test, then replace.
    always_comb begin
        diff_r = (red >= red_ref)     ? DIFF_W'(red) - DIFF_W'(red_ref)
                                      : DIFF_W'(red_ref) - DIFF_W'(red);
        diff_g = (green >= green_ref) ? DIFF_W'(green) - DIFF_W'(green_ref)
                                      : DIFF_W'(green_ref) - DIFF_W'(green);
        diff_b = (blue >= blue_ref)   ? DIFF_W'(blue) - DIFF_W'(blue_ref)
                                      : DIFF_W'(blue_ref) - DIFF_W'(blue);
        is_bg_c = (diff_r <= DIFF_W'(threshold)) &&
                  (diff_g <= DIFF_W'(threshold)) &&
                  (diff_b <= DIFF_W'(threshold));
        res_red_c   = is_bg_c ? bg_red   : red;
        res_green_c = is_bg_c ? bg_green : green;
        res_blue_c  = is_bg_c ? bg_blue  : blue;
    end

endmodule

// File: rtl/pe_array_stream.sv
// Multi-lane background-removal PE: SUM phase derives the frame mean, BG phase
// replaces pixels close to that mean. Optional background-lane counter is
// enabled by defining PE_BGCOUNT_EN.
module pe_array_stream
    import pe_pkg::*;
#(
    parameter int unsigned LOG2_PIXELS = 2,
    parameter int unsigned LOG2_BEATS  = 4
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic                                 Start_Sum,
    input  logic                                 Start_BgRemoval,
    input  logic                                 Ack,
    input  logic [PIX_W-1:0]                     threshold,
    input  logic [PIX_W-1:0]                     desired_bg_r,
    input  logic [PIX_W-1:0]                     desired_bg_g,
    input  logic [PIX_W-1:0]                     desired_bg_b,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [PIX_W*(2**LOG2_PIXELS)-1:0]    red_in,
    input  logic [PIX_W*(2**LOG2_PIXELS)-1:0]    green_in,
    input  logic [PIX_W*(2**LOG2_PIXELS)-1:0]    blue_in,
    output logic                                 out_valid,
    output logic [PIX_W*(2**LOG2_PIXELS)-1:0]    red_out,
    output logic [PIX_W*(2**LOG2_PIXELS)-1:0]    green_out,
    output logic [PIX_W*(2**LOG2_PIXELS)-1:0]    blue_out,
    output logic [PIX_W-1:0]                     red_exp,
    output logic [PIX_W-1:0]                     green_exp,
    output logic [PIX_W-1:0]                     blue_exp,
`ifdef PE_BGCOUNT_EN
    output logic [LOG2_PIXELS+LOG2_BEATS:0]      bg_count,
`endif
    output logic                                 Qi,
    output logic                                 Qsi,
    output logic                                 Qs,
    output logic                                 Qsd,
    output logic                                 Qbgi,
    output logic                                 Qbg,
    output logic                                 Qbgd
);

    localparam int unsigned NUM_PIXELS  = 2 ** LOG2_PIXELS;
    localparam int unsigned FRAME_BEATS = 2 ** LOG2_BEATS;
    localparam int unsigned ACC_W       = acc_width(LOG2_PIXELS, LOG2_BEATS);
    localparam int unsigned MEAN_SHIFT  = LOG2_PIXELS + LOG2_BEATS;
    localparam int unsigned SUM_W       = PIX_W + LOG2_PIXELS;
    localparam int unsigned LANE_W      = PIX_W * NUM_PIXELS;
    localparam int unsigned CNT_W       = LOG2_BEATS;

    pe_state_e state_q;
    pe_state_e state_d;

    logic [CNT_W-1:0]  beat_cnt;
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  acc_g;
    logic [ACC_W-1:0]  acc_b;
    logic [ACC_W-1:0]  acc_next_r;
    logic [ACC_W-1:0]  acc_next_g;
    logic [ACC_W-1:0]  acc_next_b;
    logic [SUM_W-1:0]  beat_r;
    logic [SUM_W-1:0]  beat_g;
    logic [SUM_W-1:0]  beat_b;
    logic [LANE_W-1:0] res_r;
    logic [LANE_W-1:0] res_g;
    logic [LANE_W-1:0] res_b;
    logic [NUM_PIXELS-1:0] lane_bg;
    logic              accept;
    logic              last_beat;

    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt == CNT_W'(FRAME_BEATS - 1));

    // State flags are the one-hot state register bits.
    assign Qi   = state_q[0];
    assign Qsi  = state_q[1];
    assign Qs   = state_q[2];
    assign Qsd  = state_q[3];
    assign Qbgi = state_q[4];
    assign Qbg  = state_q[5];
    assign Qbgd = state_q[6];

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Start_Sum wins over Start_BgRemoval.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (Start_Sum) begin
                    state_d = ST_SUM_INIT;
                end else if (Start_BgRemoval) begin
                    state_d = ST_BG_INIT;
                end
            end
            ST_SUM_INIT: state_d = ST_SUM;
            ST_SUM:      if (accept && last_beat) state_d = ST_SUM_DONE;
            ST_SUM_DONE: if (Ack) state_d = ST_INIT;
            ST_BG_INIT:  state_d = ST_BG;
            ST_BG:       if (accept && last_beat) state_d = ST_BG_DONE;
            ST_BG_DONE:  if (Ack) state_d = ST_INIT;
            default:     state_d = ST_INIT;
        endcase
    end

    // Per-channel sum of all lanes in the current beat, and running totals.
    always_comb begin
        beat_r = '0;
        beat_g = '0;
        beat_b = '0;
        for (int k = 0; k < NUM_PIXELS; k++) begin
            beat_r = beat_r + SUM_W'(red_in[PIX_W*k +: PIX_W]);
            beat_g = beat_g + SUM_W'(green_in[PIX_W*k +: PIX_W]);
            beat_b = beat_b + SUM_W'(blue_in[PIX_W*k +: PIX_W]);
        end
        acc_next_r = acc_r + ACC_W'(beat_r);
        acc_next_g = acc_g + ACC_W'(beat_g);
        acc_next_b = acc_b + ACC_W'(beat_b);
    end

    // Per-lane compare and replace against the latched mean.
    for (genvar k = 0; k < NUM_PIXELS; k++) begin : g_lane
        pe_lane u_lane (
            .red         (red_in[PIX_W*k +: PIX_W]),
            .green       (green_in[PIX_W*k +: PIX_W]),
            .blue        (blue_in[PIX_W*k +: PIX_W]),
            .red_ref     (red_exp),
            .green_ref   (green_exp),
            .blue_ref    (blue_exp),
            .threshold   (threshold),
            .bg_red      (desired_bg_r),
            .bg_green    (desired_bg_g),
            .bg_blue     (desired_bg_b),
            .res_red_c   (res_r[PIX_W*k +: PIX_W]),
            .res_green_c (res_g[PIX_W*k +: PIX_W]),
            .res_blue_c  (res_b[PIX_W*k +: PIX_W]),
            .is_bg_c     (lane_bg[k])
        );
    end

    // Datapath: ready flag, beat counter, accumulators, mean latch, output beat.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            in_ready  <= 1'b0;
            beat_cnt  <= '0;
            acc_r     <= '0;
            acc_g     <= '0;
            acc_b     <= '0;
            red_exp   <= '0;
            green_exp <= '0;
            blue_exp  <= '0;
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_d == ST_SUM) || (state_d == ST_BG);
            out_valid <= 1'b0;
            case (state_q)
                ST_SUM_INIT: begin
                    beat_cnt <= '0;
                    acc_r    <= '0;
                    acc_g    <= '0;
                    acc_b    <= '0;
                end
                ST_BG_INIT: beat_cnt <= '0;
                ST_SUM: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        acc_r    <= acc_next_r;
                        acc_g    <= acc_next_g;
                        acc_b    <= acc_next_b;
                        if (last_beat) begin
                            red_exp   <= PIX_W'(acc_next_r >> MEAN_SHIFT);
                            green_exp <= PIX_W'(acc_next_g >> MEAN_SHIFT);
                            blue_exp  <= PIX_W'(acc_next_b >> MEAN_SHIFT);
                        end
                    end
                end
                ST_BG: begin
                    if (accept) begin
                        beat_cnt  <= beat_cnt + CNT_W'(1);
                        red_out   <= res_r;
                        green_out <= res_g;
                        blue_out  <= res_b;
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PE_BGCOUNT_EN
    localparam int unsigned LANES_W = LOG2_PIXELS + 1;
    localparam int unsigned BGC_W   = LOG2_PIXELS + LOG2_BEATS + 1;

    logic [LANES_W-1:0] bg_lanes;

    // Number of background lanes in the current beat.
    always_comb begin
        bg_lanes = '0;
        for (int k = 0; k < NUM_PIXELS; k++) begin
            bg_lanes = bg_lanes + LANES_W'(lane_bg[k]);
        end
    end

    // Background-lane counter, cleared at the start of each BG frame.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            bg_count <= '0;
        end else if (state_q == ST_BG_INIT) begin
            bg_count <= '0;
        end else if (state_q == ST_BG && accept) begin
            bg_count <= bg_count + BGC_W'(bg_lanes);
        end
    end
`else
    logic unused_lane_bg;
    assign unused_lane_bg = ^lane_bg;
`endif

endmodule

// File: tb/tb_pe_array_stream.sv
// Self-checking bench for pe_array_stream with a behavioural mean/threshold model.
module tb_pe_array_stream;

    localparam int NP = 4;
    localparam int FB = 16;
    localparam int LW = 8 * NP;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start_Sum;
    logic          Start_BgRemoval;
    logic          Ack;
    logic [7:0]    threshold;
    logic [7:0]    desired_bg_r;
    logic [7:0]    desired_bg_g;
    logic [7:0]    desired_bg_b;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] red_in;
    logic [LW-1:0] green_in;
    logic [LW-1:0] blue_in;
    logic          out_valid;
    logic [LW-1:0] red_out;
    logic [LW-1:0] green_out;
    logic [LW-1:0] blue_out;
    logic [7:0]    red_exp;
    logic [7:0]    green_exp;
    logic [7:0]    blue_exp;
`ifdef PE_BGCOUNT_EN
    logic [6:0]    bg_count;
    int            m_bgc;
`endif
    logic Qi, Qsi, Qs, Qsd, Qbgi, Qbg, Qbgd;

    int n_checks = 0;
    int n_errors = 0;
    int m_er = 0;
    int m_eg = 0;
    int m_eb = 0;

    logic [7:0] fr [FB][NP];
    logic [7:0] fg [FB][NP];
    logic [7:0] fb [FB][NP];

    always #5 Clk = ~Clk;

    pe_array_stream dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Start_Sum       (Start_Sum),
        .Start_BgRemoval (Start_BgRemoval),
        .Ack             (Ack),
        .threshold       (threshold),
        .desired_bg_r    (desired_bg_r),
        .desired_bg_g    (desired_bg_g),
        .desired_bg_b    (desired_bg_b),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .red_in          (red_in),
        .green_in        (green_in),
        .blue_in         (blue_in),
        .out_valid       (out_valid),
        .red_out         (red_out),
        .green_out       (green_out),
        .blue_out        (blue_out),
        .red_exp         (red_exp),
        .green_exp       (green_exp),
        .blue_exp        (blue_exp),
`ifdef PE_BGCOUNT_EN
        .bg_count        (bg_count),
`endif
        .Qi              (Qi),
        .Qsi             (Qsi),
        .Qs              (Qs),
        .Qsd             (Qsd),
        .Qbgi            (Qbgi),
        .Qbg             (Qbg),
        .Qbgd            (Qbgd)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_beat(input int b);
        for (int k = 0; k < NP; k++) begin
            red_in[8*k +: 8]   = fr[b][k];
            green_in[8*k +: 8] = fg[b][k];
            blue_in[8*k +: 8]  = fb[b][k];
        end
    endtask

    task automatic load_garbage();
        red_in   = LW'($urandom);
        green_in = LW'($urandom);
        blue_in  = LW'($urandom);
    endtask

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Model: a pixel is background when every channel is within threshold of the mean.
    function automatic bit model_is_bg(input int r, input int g, input int b, input int th);
        return (absdiff(r, m_er) <= th) && (absdiff(g, m_eg) <= th) && (absdiff(b, m_eb) <= th);
    endfunction

    task automatic go_sum();
        Start_Sum = 1'b1;
        tick();
        Start_Sum = 1'b0;
        for (int i = 0; i < 4 && Qs !== 1'b1; i++) tick();
        n_checks++;
        if (Qs !== 1'b1) begin
            n_errors++;
            $display("FAIL enter_sum: Qs=%b required 1", Qs);
        end
    endtask

    task automatic go_bg();
        Start_BgRemoval = 1'b1;
        tick();
        Start_BgRemoval = 1'b0;
        for (int i = 0; i < 4 && Qbg !== 1'b1; i++) tick();
        n_checks++;
        if (Qbg !== 1'b1) begin
            n_errors++;
            $display("FAIL enter_bg: Qbg=%b required 1", Qbg);
        end
    endtask

    task automatic do_ack();
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        n_checks++;
        if (Qi !== 1'b1) begin
            n_errors++;
            $display("FAIL ack_to_init: Qi=%b required 1", Qi);
        end
    endtask

    // Streams the frame arrays through SUM and checks the latched truncating mean.
    task automatic run_sum(input logic [15:0] stall_mask);
        int sr, sg, sb;
        sr = 0; sg = 0; sb = 0;
        for (int b = 0; b < FB; b++) begin
            if (stall_mask[b]) begin
                in_valid = 1'b0;
                load_garbage();
                tick();
            end
            in_valid = 1'b1;
            load_beat(b);
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < NP; k++) begin
                sr += int'(fr[b][k]);
                sg += int'(fg[b][k]);
                sb += int'(fb[b][k]);
            end
        end
        m_er = sr / (NP * FB);
        m_eg = sg / (NP * FB);
        m_eb = sb / (NP * FB);
        n_checks++;
        if (Qsd !== 1'b1) begin
            n_errors++;
            $display("FAIL sum_done: Qsd=%b required 1", Qsd);
        end
        n_checks++;
        if (red_exp !== 8'(m_er) || green_exp !== 8'(m_eg) || blue_exp !== 8'(m_eb)) begin
            n_errors++;
            $display("FAIL sum_mean: exp=(%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     red_exp, green_exp, blue_exp, m_er, m_eg, m_eb);
        end
    endtask

    // Streams the frame arrays through BG and checks every output beat against the model.
    task automatic run_bg(input logic [15:0] stall_mask);
        logic [LW-1:0] er, eg, eb;
        int th;
        th = int'(threshold);
        er = '0; eg = '0; eb = '0;
`ifdef PE_BGCOUNT_EN
        m_bgc = 0;
`endif
        for (int b = 0; b < FB; b++) begin
            if (stall_mask[b]) begin
                in_valid = 1'b0;
                load_garbage();
                tick();
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL bg_stall%0d: out_valid=%b required 0", b, out_valid);
                end
            end
            in_valid = 1'b1;
            load_beat(b);
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < NP; k++) begin
                if (model_is_bg(int'(fr[b][k]), int'(fg[b][k]), int'(fb[b][k]), th)) begin
                    er[8*k +: 8] = desired_bg_r;
                    eg[8*k +: 8] = desired_bg_g;
                    eb[8*k +: 8] = desired_bg_b;
`ifdef PE_BGCOUNT_EN
                    m_bgc++;
`endif
                end else begin
                    er[8*k +: 8] = fr[b][k];
                    eg[8*k +: 8] = fg[b][k];
                    eb[8*k +: 8] = fb[b][k];
                end
            end
            n_checks++;
            if (out_valid !== 1'b1 || red_out !== er || green_out !== eg || blue_out !== eb) begin
                n_errors++;
                $display("FAIL bg_beat%0d: valid=%b out=(%h,%h,%h) required valid=1 out=(%h,%h,%h)",
                         b, out_valid, red_out, green_out, blue_out, er, eg, eb);
            end
        end
        n_checks++;
        if (Qbgd !== 1'b1) begin
            n_errors++;
            $display("FAIL bg_done: Qbgd=%b required 1", Qbgd);
        end
        load_garbage();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || red_out !== er || green_out !== eg || blue_out !== eb || Qbgd !== 1'b1) begin
            n_errors++;
            $display("FAIL bg_hold: valid=%b Qbgd=%b out=(%h,%h,%h) required valid=0 Qbgd=1 out=(%h,%h,%h)",
                     out_valid, Qbgd, red_out, green_out, blue_out, er, eg, eb);
        end
`ifdef PE_BGCOUNT_EN
        n_checks++;
        if (bg_count !== 7'(m_bgc)) begin
            n_errors++;
            $display("FAIL bg_count: got %0d required %0d", bg_count, m_bgc);
        end
`endif
    endtask

    task automatic check_reset_state(input string tag);
        n_checks++;
        if ({Qi, Qsi, Qs, Qsd, Qbgi, Qbg, Qbgd} !== 7'b1000000 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_flags: Q=%b in_ready=%b out_valid=%b required Q=1000000 0 0",
                     tag, {Qi, Qsi, Qs, Qsd, Qbgi, Qbg, Qbgd}, in_ready, out_valid);
        end
        n_checks++;
        if (red_exp !== 8'd0 || green_exp !== 8'd0 || blue_exp !== 8'd0 ||
            red_out !== '0 || green_out !== '0 || blue_out !== '0) begin
            n_errors++;
            $display("FAIL %s_data: exp=(%0d,%0d,%0d) out=(%h,%h,%h) required all 0",
                     tag, red_exp, green_exp, blue_exp, red_out, green_out, blue_out);
        end
`ifdef PE_BGCOUNT_EN
        n_checks++;
        if (bg_count !== 7'd0) begin
            n_errors++;
            $display("FAIL %s_bgcount: got %0d required 0", tag, bg_count);
        end
`endif
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        check_reset_state("reset_init");
    endtask

    task automatic test_sum_uniform();
        for (int b = 0; b < FB; b++)
            for (int k = 0; k < NP; k++) begin
                fr[b][k] = 8'd61; fg[b][k] = 8'd133; fb[b][k] = 8'd198;
            end
        go_sum();
        run_sum(16'h0888);
        n_checks++;
        if (red_exp !== 8'd61 || green_exp !== 8'd133 || blue_exp !== 8'd198) begin
            n_errors++;
            $display("FAIL uniform_mean: exp=(%0d,%0d,%0d) required (61,133,198)",
                     red_exp, green_exp, blue_exp);
        end
        do_ack();
    endtask

    task automatic test_bg_alternate();
        threshold = 8'd30;
        desired_bg_r = 8'd10; desired_bg_g = 8'd10; desired_bg_b = 8'd10;
        for (int b = 0; b < FB; b++)
            for (int k = 0; k < NP; k++) begin
                if (k % 2 == 0) begin
                    fr[b][k] = 8'd61; fg[b][k] = 8'd133; fb[b][k] = 8'd198;
                end else begin
                    fr[b][k] = 8'd200; fg[b][k] = 8'd20; fb[b][k] = 8'd20;
                end
            end
        go_bg();
        run_bg(16'h0000);
        n_checks++;
        if (red_out[7:0] !== 8'd10 || red_out[15:8] !== 8'd200 || blue_out[31:24] !== 8'd20) begin
            n_errors++;
            $display("FAIL alt_lanes: red_out=%h blue_out=%h required lane0 r=0a lane1 r=c8 lane3 b=14",
                     red_out, blue_out);
        end
        do_ack();
    endtask

    task automatic test_boundary();
        threshold = 8'd30;
        for (int b = 0; b < FB; b++) begin
            fr[b][0] = 8'd91;  fg[b][0] = 8'd133; fb[b][0] = 8'd198;
            fr[b][1] = 8'd92;  fg[b][1] = 8'd133; fb[b][1] = 8'd198;
            fr[b][2] = 8'd61;  fg[b][2] = 8'd103; fb[b][2] = 8'd198;
            fr[b][3] = 8'd61;  fg[b][3] = 8'd133; fb[b][3] = 8'd167;
        end
        go_bg();
        run_bg(16'h0101);
        n_checks++;
        if (red_out[7:0] !== 8'd10 || red_out[15:8] !== 8'd92 ||
            green_out[23:16] !== 8'd10 || blue_out[31:24] !== 8'd167) begin
            n_errors++;
            $display("FAIL thr_edge: red=%h green=%h blue=%h required r0=0a r1=5c g2=0a b3=a7",
                     red_out, green_out, blue_out);
        end
        do_ack();

        threshold = 8'd0;
        for (int b = 0; b < FB; b++)
            for (int k = 0; k < NP; k++) begin
                fr[b][k] = (k % 2 == 0) ? 8'd61 : 8'd62;
                fg[b][k] = 8'd133; fb[b][k] = 8'd198;
            end
        go_bg();
        run_bg(16'h0000);
        n_checks++;
        if (red_out[7:0] !== 8'd10 || red_out[15:8] !== 8'd62) begin
            n_errors++;
            $display("FAIL thr_zero: red_out=%h required lane0=0a lane1=3e", red_out);
        end
        do_ack();

        threshold = 8'd255;
        desired_bg_r = 8'd1; desired_bg_g = 8'd2; desired_bg_b = 8'd3;
        for (int b = 0; b < FB; b++)
            for (int k = 0; k < NP; k++) begin
                fr[b][k] = 8'($urandom); fg[b][k] = 8'($urandom); fb[b][k] = 8'($urandom);
            end
        go_bg();
        run_bg(16'h2000);
        n_checks++;
        if (red_out !== {NP{8'd1}} || green_out !== {NP{8'd2}} || blue_out !== {NP{8'd3}}) begin
            n_errors++;
            $display("FAIL thr_full: out=(%h,%h,%h) required all lanes (01,02,03)",
                     red_out, green_out, blue_out);
        end
        do_ack();
    endtask

    task automatic test_reset_mid_sum();
        go_sum();
        for (int b = 0; b < 5; b++) begin
            in_valid = 1'b1;
            load_garbage();
            tick();
        end
        in_valid = 1'b0;
        Reset = 1'b0;
        repeat (5) tick();
        Reset = 1'b1;
        check_reset_state("reset_mid");
        m_er = 0; m_eg = 0; m_eb = 0;
    endtask

    task automatic test_start_priority_and_random_sum();
        Start_Sum = 1'b1;
        Start_BgRemoval = 1'b1;
        tick();
        Start_Sum = 1'b0;
        Start_BgRemoval = 1'b0;
        n_checks++;
        if (Qsi !== 1'b1 || Qbgi !== 1'b0) begin
            n_errors++;
            $display("FAIL start_prio: Qsi=%b Qbgi=%b required 1 0", Qsi, Qbgi);
        end
        tick();
        Start_BgRemoval = 1'b1;
        Ack = 1'b1;
        tick();
        Start_BgRemoval = 1'b0;
        Ack = 1'b0;
        n_checks++;
        if (Qs !== 1'b1 || Qbgi !== 1'b0 || Qi !== 1'b0) begin
            n_errors++;
            $display("FAIL start_ignored: Qs=%b Qbgi=%b Qi=%b required 1 0 0", Qs, Qbgi, Qi);
        end
        for (int b = 0; b < FB; b++)
            for (int k = 0; k < NP; k++) begin
                fr[b][k] = 8'($urandom); fg[b][k] = 8'($urandom); fb[b][k] = 8'($urandom);
            end
        fr[0][0] = 8'd0;   fg[0][0] = 8'd255; fb[0][0] = 8'd0;
        fr[1][1] = 8'd255; fg[1][1] = 8'd0;   fb[1][1] = 8'd255;
        run_sum(16'($urandom));
        do_ack();
    endtask

    task automatic test_bg_random();
        threshold = 8'($urandom_range(15, 45));
        desired_bg_r = 8'($urandom); desired_bg_g = 8'($urandom); desired_bg_b = 8'($urandom);
        for (int b = 0; b < FB; b++)
            for (int k = 0; k < NP; k++) begin
                fr[b][k] = 8'(clamp8(m_er + int'($urandom_range(0, 100)) - 50));
                fg[b][k] = 8'(clamp8(m_eg + int'($urandom_range(0, 100)) - 50));
                fb[b][k] = 8'(clamp8(m_eb + int'($urandom_range(0, 100)) - 50));
            end
        go_bg();
        run_bg(16'($urandom));
        do_ack();
    endtask

    initial begin
        Reset = 1'b0;
        Start_Sum = 1'b0;
        Start_BgRemoval = 1'b0;
        Ack = 1'b0;
        threshold = 8'd0;
        desired_bg_r = 8'd0; desired_bg_g = 8'd0; desired_bg_b = 8'd0;
        in_valid = 1'b0;
        red_in = '0; green_in = '0; blue_in = '0;

        test_reset();
        test_sum_uniform();
        test_bg_alternate();
        test_boundary();
        test_reset_mid_sum();
        test_start_priority_and_random_sum();
        test_bg_random();
        test_bg_random();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
